// File: rtl/div_unit_iter.sv
// rtl/div_unit_iter.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module div_unit_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         kill,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state, state_nx;

    // operation context captured on acceptance
    logic           is_rem;
    logic           neg_q;
    logic           neg_r;
    logic           spec;
    logic [N-1:0]   bmag;
    logic [N-1:0]   dvd;
    logic [N:0]     rem;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   result_r;

    // start seen in the FIN cycle, replayed from IDLE on the following cycle
    logic           pend;
    logic [1:0]     pend_op;
    logic [N-1:0]   pend_a;
    logic [N-1:0]   pend_b;

    logic           go;
    logic [1:0]     s_op;
    logic [N-1:0]   s_a;
    logic [N-1:0]   s_b;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           div0;
    logic           ovf;
    logic [N-1:0]   spec_val;

    logic [N:0]     rem_sh;
    logic           ge;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic [N-1:0]   fin_val;

    // operand selection, magnitudes and RISC-V special-case detection
    always_comb begin
        go       = (start | pend) & ~kill;
        s_op     = pend ? pend_op : op;
        s_a      = pend ? pend_a  : a;
        s_b      = pend ? pend_b  : b;
        a_neg    = ~s_op[0] & s_a[N-1];
        b_neg    = ~s_op[0] & s_b[N-1];
        a_mag    = a_neg ? (~s_a + 1'b1) : s_a;
        b_mag    = b_neg ? (~s_b + 1'b1) : s_b;
        div0     = (s_b == '0);
        ovf      = ~s_op[0] & (s_a == {1'b1, {(N-1){1'b0}}}) & (s_b == '1);
        spec_val = '0;
        if (div0)
            spec_val = s_op[1] ? s_a : '1;
        else
            spec_val = s_op[1] ? '0 : s_a;
    end

    // one restoring step plus the final sign fix-up
    always_comb begin
        rem_sh  = {rem[N-1:0], dvd[N-1]};
        ge      = (rem_sh >= {1'b0, bmag});
        q_fix   = neg_q ? (~dvd + 1'b1) : dvd;
        r_fix   = neg_r ? (~rem[N-1:0] + 1'b1) : rem[N-1:0];
        fin_val = spec ? dvd : (is_rem ? r_fix : q_fix);
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (go) state_nx = (div0 | ovf) ? FIN : CALC;
            CALC: begin
                if (kill)
                    state_nx = IDLE;
                else if (cnt == CW'(1))
                    state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // datapath: capture on accept, shift/subtract in CALC, publish in FIN
    always_ff @(posedge clk) begin
        if (rst) begin
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            spec     <= 1'b0;
            bmag     <= '0;
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
            result_r <= '0;
            pend     <= 1'b0;
            pend_op  <= '0;
            pend_a   <= '0;
            pend_b   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pend <= 1'b0;
                    if (go) begin
                        is_rem <= s_op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        spec   <= div0 | ovf;
                        bmag   <= b_mag;
                        rem    <= '0;
                        cnt    <= CW'(N);
                        dvd    <= (div0 | ovf) ? spec_val : a_mag;
                    end
                end
                CALC: begin
                    if (!kill) begin
                        dvd <= {dvd[N-2:0], ge};
                        rem <= ge ? (rem_sh - {1'b0, bmag}) : rem_sh;
                        cnt <= cnt - CW'(1);
                    end
                end
                FIN: begin
                    if (!kill) begin
                        result_r <= fin_val;
                        if (start) begin
                            pend    <= 1'b1;
                            pend_op <= op;
                            pend_a  <= a;
                            pend_b  <= b;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == CALC);
    assign done   = (state == FIN) & ~kill;
    assign result = done ? fin_val : result_r;

endmodule
